// File: rtl/imem_port_ctrl.sv
// Instruction-memory port controller: arbitrates fetch vs loader onto one synchronous SRAM
// port, with bounded loader starvation and fixed one-cycle response latency.
module imem_port_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              f_req_i,
  input  logic [31:0]       f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [31:0]       f_rdata_o,
  output logic              f_err_o,
  input  logic              l_req_i,
  input  logic              l_we_i,
  input  logic [31:0]       l_addr_i,
  input  logic [3:0]        l_be_i,
  input  logic [31:0]       l_wdata_i,
  input  logic              l_lock_i,
  output logic              l_gnt_o,
  output logic              l_rvalid_o,
  output logic [31:0]       l_rdata_o,
  output logic              l_err_o,
  output logic              m_en_o,
  output logic [3:0]        m_we_o,
  output logic [ADDR_W-3:0] m_addr_o,
  output logic [31:0]       m_wdata_o,
  input  logic [31:0]       m_rdata_i
);

  localparam int          SW  = $clog2(STARVE_MAX + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_FETCH_ERR,
    OWN_LOAD_RD,
    OWN_LOAD_WR,
    OWN_LOAD_ERR
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          f_bad, l_bad, starve_hit, l_win, f_win;

  function automatic logic in_range(input logic [31:0] a);
    return (a >> ADDR_W) == 32'd0;
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_MAX)) ? v : v + SW'(1);
  endfunction

  always_comb begin
    f_bad      = (f_addr_i[1:0] != 2'b00) || !in_range(f_addr_i);
    l_bad      = !in_range(l_addr_i);
    starve_hit = (starve_q == SW'(STARVE_MAX));
    // Grants are held low throughout reset, independent of the requests.
    l_win      = rst_ni && l_req_i && (l_lock_i || !f_req_i || starve_hit);
    f_win      = rst_ni && f_req_i && !l_lock_i && !l_win;

    f_gnt_o   = f_win;
    l_gnt_o   = l_win;
    m_en_o    = 1'b0;
    m_we_o    = 4'b0000;
    m_addr_o  = '0;
    m_wdata_o = '0;
    owner_d   = OWN_NONE;
    starve_d  = (l_req_i && !l_win) ? sat_inc(starve_q) : '0;

    if (l_win) begin
      if (l_bad) begin
        owner_d = OWN_LOAD_ERR;
      end else begin
        owner_d   = l_we_i ? OWN_LOAD_WR : OWN_LOAD_RD;
        m_en_o    = 1'b1;
        m_we_o    = l_we_i ? l_be_i : 4'b0000;
        m_addr_o  = l_addr_i[ADDR_W-1:2];
        m_wdata_o = l_wdata_i;
      end
    end else if (f_win) begin
      if (f_bad) begin
        owner_d = OWN_FETCH_ERR;
      end else begin
        owner_d   = OWN_FETCH;
        m_en_o    = 1'b1;
        m_addr_o  = f_addr_i[ADDR_W-1:2];
        m_wdata_o = l_wdata_i;
      end
    end
  end

  // Request stage -> response stage: remember who owns the SRAM result next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    f_rvalid_o = 1'b0;
    f_err_o    = 1'b0;
    f_rdata_o  = '0;
    l_rvalid_o = 1'b0;
    l_err_o    = 1'b0;
    l_rdata_o  = '0;
    case (owner_q)
      OWN_FETCH: begin
        f_rvalid_o = 1'b1;
        f_rdata_o  = m_rdata_i;
      end
      OWN_FETCH_ERR: begin
        f_rvalid_o = 1'b1;
        f_err_o    = 1'b1;
        f_rdata_o  = NOP;
      end
      OWN_LOAD_RD: begin
        l_rvalid_o = 1'b1;
        l_rdata_o  = m_rdata_i;
      end
      OWN_LOAD_WR: l_rvalid_o = 1'b1;
      OWN_LOAD_ERR: begin
        l_rvalid_o = 1'b1;
        l_err_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Bench for imem_port_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_imem_port_ctrl;

  localparam int ADDR_W     = 13;
  localparam int STARVE_MAX = 4;
  localparam int WORDS      = 1 << (ADDR_W - 2);
  localparam logic [32:0] LIMIT = 33'(1) << ADDR_W;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              f_req_i;
  logic [31:0]       f_addr_i;
  logic              f_gnt_o;
  logic              f_rvalid_o;
  logic [31:0]       f_rdata_o;
  logic              f_err_o;
  logic              l_req_i;
  logic              l_we_i;
  logic [31:0]       l_addr_i;
  logic [3:0]        l_be_i;
  logic [31:0]       l_wdata_i;
  logic              l_lock_i;
  logic              l_gnt_o;
  logic              l_rvalid_o;
  logic [31:0]       l_rdata_o;
  logic              l_err_o;
  logic              m_en_o;
  logic [3:0]        m_we_o;
  logic [ADDR_W-3:0] m_addr_o;
  logic [31:0]       m_wdata_o;
  logic [31:0]       m_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  imem_port_ctrl #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
    .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
    .l_req_i(l_req_i), .l_we_i(l_we_i), .l_addr_i(l_addr_i), .l_be_i(l_be_i),
    .l_wdata_i(l_wdata_i), .l_lock_i(l_lock_i), .l_gnt_o(l_gnt_o),
    .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o), .l_err_o(l_err_o),
    .m_en_o(m_en_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0050_0093;
      1:       return 32'h0010_0113;
      2:       return 32'h0020_81b3;
      4:       return 32'h1122_3344;
      default: return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous SRAM seen by the DUT; unread cycles return noise.
  logic [31:0] mem [0:WORDS-1];
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk_i);
      if (m_en_o && m_we_o == 4'b0000) m_rdata_i <= mem[m_addr_o];
      else                             m_rdata_i <= $urandom;
      if (m_en_o)
        for (int b = 0; b < 4; b++)
          if (m_we_o[b]) mem[m_addr_o][8*b +: 8] <= m_wdata_o[8*b +: 8];
    end
  end

  // Transaction-level model and per-cycle comparison.
  logic [31:0] ref_mem [0:WORDS-1];
  int          wait_cnt;
  logic        pf_v, pf_e, pl_v, pl_e;
  logic [31:0] pf_d, pl_d;
  logic        lw, fw, f_ok, l_ok, e_en;
  logic [3:0]  e_we;
  int          e_idx;

  initial begin
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
    wait_cnt = 0;
    pf_v = 0; pf_e = 0; pf_d = 0; pl_v = 0; pl_e = 0; pl_d = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        chk("rst_f_gnt", 32'(f_gnt_o), 0);
        chk("rst_l_gnt", 32'(l_gnt_o), 0);
        chk("rst_m_en", 32'(m_en_o), 0);
        chk("rst_m_we", 32'(m_we_o), 0);
        chk("rst_m_addr", 32'(m_addr_o), 0);
        chk("rst_m_wdata", m_wdata_o, 0);
        chk("rst_f_rvalid", 32'(f_rvalid_o), 0);
        chk("rst_f_err", 32'(f_err_o), 0);
        chk("rst_l_rvalid", 32'(l_rvalid_o), 0);
        chk("rst_l_err", 32'(l_err_o), 0);
        wait_cnt = 0;
        pf_v = 0; pf_e = 0; pf_d = 0; pl_v = 0; pl_e = 0; pl_d = 0;
      end else begin
        chk("f_rvalid", 32'(f_rvalid_o), 32'(pf_v));
        chk("f_err", 32'(f_err_o), 32'(pf_e));
        chk("f_rdata", f_rdata_o, pf_d);
        chk("l_rvalid", 32'(l_rvalid_o), 32'(pl_v));
        chk("l_err", 32'(l_err_o), 32'(pl_e));
        chk("l_rdata", l_rdata_o, pl_d);

        lw   = l_req_i && (l_lock_i || !f_req_i || wait_cnt >= STARVE_MAX);
        fw   = f_req_i && !l_lock_i && !lw;
        f_ok = (f_addr_i % 4 == 0) && (33'(f_addr_i) < LIMIT);
        l_ok = 33'(l_addr_i) < LIMIT;
        e_en = 0; e_we = 0; e_idx = 0;
        if (lw && l_ok) begin
          e_en = 1; e_idx = int'((l_addr_i / 4) % WORDS);
          e_we = l_we_i ? l_be_i : 4'b0000;
        end else if (fw && f_ok) begin
          e_en = 1; e_idx = int'((f_addr_i / 4) % WORDS);
        end
        chk("f_gnt", 32'(f_gnt_o), 32'(fw));
        chk("l_gnt", 32'(l_gnt_o), 32'(lw));
        chk("m_en", 32'(m_en_o), 32'(e_en));
        if (e_en) begin
          chk("m_addr", 32'(m_addr_o), 32'(e_idx));
          chk("m_we", 32'(m_we_o), 32'(e_we));
        end
        if (e_we != 4'b0000) chk("m_wdata", m_wdata_o, l_wdata_i);

        pf_v = fw;
        pf_e = fw && !f_ok;
        pf_d = !fw ? 32'h0 : (f_ok ? ref_mem[e_idx] : 32'h0000_0013);
        pl_v = lw;
        pl_e = lw && !l_ok;
        pl_d = (lw && l_ok && !l_we_i) ? ref_mem[e_idx] : 32'h0;
        if (lw && l_ok && l_we_i)
          for (int b = 0; b < 4; b++)
            if (l_be_i[b]) ref_mem[e_idx][8*b +: 8] = l_wdata_i[8*b +: 8];
        wait_cnt = (l_req_i && !lw) ? wait_cnt + 1 : 0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 63)) << 2;
    case ($urandom_range(0, 19))
      0:       a = a | 32'($urandom_range(1, 3));
      1:       a = a | (32'd1 << $urandom_range(ADDR_W, 31));
      2:       a = 32'h0000_1FFC;
      default: ;
    endcase
    return a;
  endfunction

  logic [9:0] lpat, fpat;
  logic       fg, lg;

  initial begin
    rst_ni = 0; f_req_i = 1; f_addr_i = 0; l_req_i = 1; l_we_i = 0;
    l_addr_i = 0; l_be_i = 0; l_wdata_i = 0; l_lock_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_f_gnt", 32'(f_gnt_o), 0);
    chk("reset_m_en", 32'(m_en_o), 0);

    // Back-to-back fetch of the preloaded program
    step; rst_ni = 1; l_req_i = 0; f_req_i = 1; f_addr_i = 32'h0;
    @(negedge clk_i); chk("fetch0_gnt", 32'(f_gnt_o), 1);
    step; f_addr_i = 32'h4;
    @(negedge clk_i); chk("fetch1_gnt", 32'(f_gnt_o), 1);
    chk("fetch0_rdata", f_rdata_o, 32'h0050_0093);
    step; f_addr_i = 32'h8;
    @(negedge clk_i); chk("fetch1_rdata", f_rdata_o, 32'h0010_0113);
    step; f_req_i = 0;
    @(negedge clk_i); chk("fetch2_rdata", f_rdata_o, 32'h0020_81b3);
    chk("fetch2_err", 32'(f_err_o), 0);

    // Partial write then read-back
    step; l_req_i = 1; l_we_i = 1; l_addr_i = 32'h10; l_be_i = 4'b0101; l_wdata_i = 32'hAABB_CCDD;
    @(negedge clk_i); chk("wr_gnt", 32'(l_gnt_o), 1); chk("wr_m_we", 32'(m_we_o), 32'h5);
    step; l_we_i = 0;
    @(negedge clk_i); chk("wr_ack", 32'(l_rvalid_o), 1); chk("wr_ack_rdata", l_rdata_o, 0);
    step; l_req_i = 0;
    @(negedge clk_i); chk("rd_rvalid", 32'(l_rvalid_o), 1); chk("rd_rdata", l_rdata_o, 32'h11BB_33DD);

    // Contention: 4 fetch grants then 1 loader grant, repeating
    step; f_req_i = 1; f_addr_i = 32'h20; l_req_i = 1; l_we_i = 0; l_addr_i = 32'h40;
    lpat = '0; fpat = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i); lpat[i] = l_gnt_o; fpat[i] = f_gnt_o;
      step;
    end
    chk("starve_l_pattern", 32'(lpat), 32'h210);
    chk("starve_f_pattern", 32'(fpat), 32'h1EF);

    // Misaligned / out-of-range fetch, out-of-range loader read
    l_req_i = 0; f_addr_i = 32'h2;
    @(negedge clk_i); chk("ferr_mis_gnt", 32'(f_gnt_o), 1); chk("ferr_mis_m_en", 32'(m_en_o), 0);
    step; f_addr_i = 32'h0000_2000;
    @(negedge clk_i); chk("ferr_oor_m_en", 32'(m_en_o), 0);
    chk("ferr_mis_err", 32'(f_err_o), 1); chk("ferr_mis_rdata", f_rdata_o, 32'h13);
    step; f_req_i = 0; l_req_i = 1; l_we_i = 0; l_addr_i = 32'h4000_0000;
    @(negedge clk_i); chk("ferr_oor_err", 32'(f_err_o), 1); chk("ferr_oor_rdata", f_rdata_o, 32'h13);
    chk("lerr_gnt", 32'(l_gnt_o), 1); chk("lerr_m_en", 32'(m_en_o), 0);
    step; l_req_i = 0;
    @(negedge clk_i); chk("lerr_err", 32'(l_err_o), 1); chk("lerr_rdata", l_rdata_o, 0);

    // Lock asserted right after a fetch grant
    step; f_req_i = 1; f_addr_i = 32'h8;
    @(negedge clk_i); chk("prelock_f_gnt", 32'(f_gnt_o), 1);
    step; l_lock_i = 1; l_req_i = 1; l_addr_i = 32'h44; l_we_i = 0;
    @(negedge clk_i); chk("lock_f_rvalid", 32'(f_rvalid_o), 1);
    for (int i = 0; i < 3; i++) begin
      chk("lock_f_gnt", 32'(f_gnt_o), 0); chk("lock_l_gnt", 32'(l_gnt_o), 1);
      step; @(negedge clk_i);
    end
    step; l_lock_i = 0; l_req_i = 0;
    @(negedge clk_i); chk("unlock_f_gnt", 32'(f_gnt_o), 1);

    // Reset right after a fetch grant drops its response
    step; f_addr_i = 32'hC;
    @(negedge clk_i); chk("prerst_f_gnt", 32'(f_gnt_o), 1);
    step; rst_ni = 0; l_req_i = 1;
    @(negedge clk_i); chk("midrst_f_rvalid", 32'(f_rvalid_o), 0); chk("midrst_l_gnt", 32'(l_gnt_o), 0);
    step; step; rst_ni = 1;
    @(negedge clk_i); chk("postrst_f_gnt", 32'(f_gnt_o), 1); chk("postrst_l_gnt", 32'(l_gnt_o), 0);
    chk("postrst_f_rvalid", 32'(f_rvalid_o), 0);

    // Randomized traffic, each requester holding until granted
    step; f_req_i = 0; l_req_i = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i); fg = f_gnt_o; lg = l_gnt_o;
      step;
      if (!f_req_i || fg) begin
        f_req_i  = ($urandom_range(0, 3) != 0);
        f_addr_i = rand_addr();
      end
      if (!l_req_i || lg) begin
        l_req_i   = ($urandom_range(0, 1) == 0);
        l_we_i    = 1'($urandom_range(0, 1));
        l_addr_i  = rand_addr() | 32'($urandom_range(0, 3));
        l_be_i    = 4'($urandom_range(0, 15));
        l_wdata_i = $urandom;
      end
      if ($urandom_range(0, 31) == 0) l_lock_i = !l_lock_i;
    end
    step; f_req_i = 0; l_req_i = 0; l_lock_i = 0;
    repeat (3) step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_port_ctrl.md
# imem_port_ctrl

Single-port controller for the core's 8 KiB instruction memory. It arbitrates between the pipeline fetch stage (read-only) and the program loader/debug port (read/write), drives the word-wide synchronous SRAM with byte enables, and returns read data with fixed one-cycle latency. It also flags misaligned and out-of-range fetches, and guarantees the loader forward progress under continuous fetch traffic.

## Interface
- `ADDR_W`, default 13: byte-address width of the memory (2^ADDR_W bytes).
- `STARVE_MAX`, default 4: consecutive loader-denied cycles before the loader is forced to win (≥1).
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: asynchronous active-low reset.
- `f_req_i` in 1: fetch request.
- `f_addr_i` in 32: fetch byte address.
- `f_gnt_o` out 1: fetch accepted this cycle.
- `f_rvalid_o` out 1: fetch response valid.
- `f_rdata_o` out 32: fetched instruction.
- `f_err_o` out 1: response is an error (misaligned or out of range); qualified by `f_rvalid_o`.
- `l_req_i` in 1: loader request.
- `l_we_i` in 1: 1 = write, 0 = read.
- `l_addr_i` in 32: loader byte address; bits [1:0] ignored.
- `l_be_i` in 4: write byte enables.
- `l_wdata_i` in 32: write data.
- `l_lock_i` in 1: loader exclusive mode (core halted).
- `l_gnt_o` out 1: loader accepted this cycle.
- `l_rvalid_o` out 1: loader response (read data or write ack).
- `l_rdata_o` out 32: read data; 0 for write acks and errors.
- `l_err_o` out 1: loader address out of range.
- `m_en_o` out 1: SRAM enable.
- `m_we_o` out 4: SRAM byte write enables.
- `m_addr_o` out ADDR_W-2: SRAM word index.
- `m_wdata_o` out 32: SRAM write data.
- `m_rdata_i` in 32: SRAM read data, valid the cycle after `m_en_o` with `m_we_o`=0.

## Operation
- Arbitration is combinational and happens every cycle; at most one grant per cycle.
  - Default: fetch has priority.
  - `l_lock_i`=1: only the loader can be granted; `f_gnt_o`=0.
  - Starvation counter `starve_q` (0..STARVE_MAX): increments when `l_req_i`=1 and the loader is not granted; clears on loader grant or when `l_req_i`=0.
  - When `starve_q`==STARVE_MAX, the loader wins over fetch for that cycle.
- A request is granted in the cycle its `*_req_i` is high and it wins arbitration.
  - The requester holds address and data stable until granted.
  - A new request may be issued in the cycle after a grant (back-to-back).
- Range check: an address is in range iff bits [31:ADDR_W] are 0.
- Fetch error: `f_addr_i[1:0]`≠0 or out of range.
  - Still granted under normal arbitration.
  - `m_en_o`=0 for that cycle (SRAM not accessed).
  - Next-cycle response: `f_rvalid_o`=1, `f_err_o`=1, `f_rdata_o`=0x0000_0013 (NOP).
- Loader error: out of range.
  - Granted; no SRAM access.
  - Next-cycle response: `l_rvalid_o`=1, `l_err_o`=1, `l_rdata_o`=0.
- SRAM drive for a granted in-range access:
  - `m_en_o`=1.
  - `m_addr_o`=addr[ADDR_W-1:2].
  - `m_we_o`=`l_be_i` if loader write, else 0.
  - `m_wdata_o`=`l_wdata_i`.
- Write with `l_be_i`=0: SRAM accessed with `m_we_o`=0; ack still returned.
- Response tracking: registered `owner_q` ∈ {NONE, FETCH, FETCH_ERR, LOAD_RD, LOAD_WR, LOAD_ERR}, set from the grant each cycle.
  - The response mux uses `owner_q`.
  - `f_rdata_o`/`l_rdata_o` pass `m_rdata_i` only for FETCH/LOAD_RD; otherwise they are 0, except the FETCH_ERR NOP.

## Timing
- Request-to-response latency: exactly 1 cycle after grant; no outstanding requests beyond one per port.
- `f_gnt_o`, `l_gnt_o`, and all `m_*` outputs are combinational from the requests and `starve_q`.
- `*_rvalid_o`, `*_err_o`, and `*_rdata_o` depend only on `owner_q` and `m_rdata_i`.
- Simultaneous requests with `starve_q`<STARVE_MAX: fetch granted, loader waits.
- Worst-case loader wait: STARVE_MAX+1 cycles.
- Reset (asynchronous assert, synchronous-safe deassert):
  - `owner_q`=NONE, `starve_q`=0.
  - All valid, err, and gnt outputs are 0, and all `m_*` outputs are 0, while `rst_ni`=0, regardless of requests.
- Reset mid-access: the pending response is dropped; no `rvalid` after reset release.
- `l_lock_i` asserted mid-stream: takes effect the same cycle; an already-granted fetch still receives its response next cycle.

## Test plan
- Back-to-back fetch from 0x0, 0x4, 0x8 with SRAM preloaded with 0x00500093, 0x00100113, 0x002081b3 → grant each cycle; `f_rvalid_o` on cycles 1–3 returns those words in order with `f_err_o`=0.
- Loader write to 0x10, data 0xAABBCCDD, `l_be_i`=0b0101, over old data 0x11223344; then loader read of 0x10 → `l_rvalid_o` ack, then read returns 0x11BB33DD.
- Continuous fetch plus continuous loader request, STARVE_MAX=4 → loader granted on its 5th cycle of waiting, then fetch resumes; repeated pattern is 4 fetch grants, 1 loader grant.
- Fetch 0x2 and fetch 0x0000_2000 (ADDR_W=13) → `m_en_o`=0; response `f_err_o`=1 with `f_rdata_o`=0x00000013. Loader read 0x4000_0000 → `l_err_o`=1, `l_rdata_o`=0.
- `l_lock_i`=1 with both requesting → only loader granted; `f_gnt_o` stays 0 until lock drops.
- Assert `rst_ni`=0 the cycle after a fetch grant → no `f_rvalid_o`. After release, all outputs are 0 and `starve_q`=0, so the first contended cycle grants fetch.
